// File: rtl/key_pkg.sv
// Shared FSM encoding and 50 MHz default timing constants for the key path.
package key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PRESS_CHK   = 3'd1,
    ST_DOWN        = 3'd2,
    ST_REPEAT      = 3'd3,
    ST_RELEASE_CHK = 3'd4
  } key_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES      = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY_CYCLES  = 25_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD_CYCLES = 5_000_000;
  localparam int unsigned DEF_CNT_W                = 26;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level with a selectable reset value.
module sync_2ff (
  input  logic clk,
  input  logic res,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; both stages reset to the caller's idle level.
  always_ff @(posedge clk) begin
    if (res) begin
      meta <= rst_val;
      q    <= rst_val;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_pulse_gen.sv
// Debounced push-button conditioner producing level, press, release and auto-repeat pulses.
// The release pulse port is named release_pulse because "release" is a reserved word.
module key_pulse_gen
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int unsigned REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES,
  parameter bit          REPEAT_EN            = 1'b1,
  parameter bit          KEY_ACTIVE_LOW       = 1'b1,
  parameter int unsigned CNT_W                = DEF_CNT_W
) (
  input  logic clk,
  input  logic res,
  input  logic key,
  output logic key_level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             key_sync;
  logic             key_s;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d, press_d, release_d, repeat_d, held_d;

  sync_2ff u_sync (
    .clk     (clk),
    .res     (res),
    .rst_val (KEY_ACTIVE_LOW),
    .d       (key),
    .q       (key_sync)
  );

  // Normalize polarity so that 1 always means pressed.
  assign key_s = key_sync ^ KEY_ACTIVE_LOW;

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      key_level     <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_level     <= level_d;
      press         <= press_d;
      release_pulse <= release_d;
      repeat_pulse  <= repeat_d;
      held          <= held_d;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = key_level;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    held_d    = held;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (key_s) state_d = ST_PRESS_CHK;
      end
      ST_PRESS_CHK: begin
        if (!key_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_DOWN;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DOWN: begin
        held_d = 1'b0;
        if (!key_s) begin
          state_d = ST_RELEASE_CHK;
          cnt_d   = '0;
        end else if (!REPEAT_EN) begin
          cnt_d = '0;
        end else if (cnt_q == DLY_LAST) begin
          state_d  = ST_REPEAT;
          repeat_d = 1'b1;
          held_d   = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_REPEAT: begin
        held_d = 1'b1;
        if (!key_s) begin
          state_d = ST_RELEASE_CHK;
          cnt_d   = '0;
        end else if (cnt_q == PER_LAST) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RELEASE_CHK: begin
        // Bounce back to pressed restarts the repeat delay from DOWN.
        if (key_s) begin
          state_d = ST_DOWN;
          held_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d   = ST_IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
          held_d    = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
        held_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/key_pulse_gen.md
# key_pulse_gen

Upstream input-conditioning stage for the push-button counter/display path. It takes one raw, asynchronous, bouncing push-button level and produces a clean debounced level plus single-cycle press, release and auto-repeat pulses in the `clk` domain. Its outputs drive the counter's increment and clear inputs directly, so the counter never sees bounce or glitches.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: number of consecutive stable cycles that qualify a level change (20 ms at 50 MHz); must be ≥ 2.
- `REPEAT_DELAY_CYCLES`, 25_000_000: cycles from `press` to the first `repeat_pulse`; must be ≥ 2.
- `REPEAT_PERIOD_CYCLES`, 5_000_000: cycles between successive `repeat_pulse`s; must be ≥ 2.
- `REPEAT_EN`, 1: 0 disables auto-repeat entirely.
- `KEY_ACTIVE_LOW`, 1: 1 means a raw 0 on `key` is "pressed".
- `CNT_W`, 26: width of the shared cycle counter; must hold max(all three cycle parameters) − 1.
- `clk` in 1: the single system clock. All logic is on the rising edge.
- `res` in 1: synchronous, active-high reset.
- `key` in 1: raw button level; asynchronous to `clk`.
- `key_level` out 1: debounced level; 1 = pressed.
- `press` out 1: one-cycle pulse when a press is qualified.
- `release` out 1: one-cycle pulse when a release is qualified.
- `repeat_pulse` out 1: one-cycle pulse for each auto-repeat tick.
- `held` out 1: high while the block is in the REPEAT state.

## Operation
- Input path: two-flop synchronizer, then polarity normalization. The result is `key_s`, where 1 = pressed.
- The FSM uses one counter `cnt` and has five states:
  - IDLE: if `key_s` = 1, go to PRESS_CHK with `cnt` = 0.
  - PRESS_CHK: if `key_s` = 0, return to IDLE (glitch rejected, no output). Otherwise increment `cnt`. When `cnt` = DEBOUNCE_CYCLES−1, go to DOWN, set `key_level` = 1, pulse `press`, and clear `cnt`.
  - DOWN: if `key_s` = 0, go to RELEASE_CHK with `cnt` = 0. Otherwise, if REPEAT_EN, increment `cnt`. When `cnt` = REPEAT_DELAY_CYCLES−1, go to REPEAT, pulse `repeat_pulse`, and clear `cnt`. If REPEAT_EN = 0, `cnt` holds at 0.
  - REPEAT: if `key_s` = 0, go to RELEASE_CHK with `cnt` = 0. Otherwise increment `cnt`. When `cnt` = REPEAT_PERIOD_CYCLES−1, pulse `repeat_pulse` and clear `cnt`.
  - RELEASE_CHK: if `key_s` = 1, go to DOWN with `cnt` = 0. This is release bounce; there is no output and the repeat delay restarts. Otherwise increment `cnt`. When `cnt` = DEBOUNCE_CYCLES−1, go to IDLE, set `key_level` = 0, pulse `release`, and clear `cnt`.
- `press`, `release` and `repeat_pulse` are mutually exclusive. Each is high for exactly one cycle.
- `held` = 1 only in REPEAT. It is also 1 in RELEASE_CHK when that state was entered from REPEAT; it drops when `release` fires or on return to DOWN.
- `key_level` stays 1 throughout DOWN, REPEAT and RELEASE_CHK.

## Timing
- All outputs are registered. There is no combinational path from `key` to any output.
- Reset: state = IDLE, `cnt` = 0, synchronizer flops = released level. `key_level`, `press`, `release`, `repeat_pulse` and `held` are all 0 in the cycle after the reset edge.
- Press latency: count the first edge that samples the new raw level as edge 1. `press` rises after edge DEBOUNCE_CYCLES+3 and falls one edge later.
- Release latency is the same: `release` rises after edge DEBOUNCE_CYCLES+3 from the first sampled release level.
- First `repeat_pulse` is exactly REPEAT_DELAY_CYCLES edges after `press`. Later pulses are exactly REPEAT_PERIOD_CYCLES apart.
- A `key_s` excursion shorter than DEBOUNCE_CYCLES in the CHK states produces no output.
- Reset mid-press: with `key` still held after `res` deasserts, the block requalifies from IDLE and issues a fresh `press` with the full press latency.
- `res` has priority over every FSM transition in the same cycle.

## Structure
- Shared package `key_pkg` holds:
  - the FSM state encoding constants (IDLE, PRESS_CHK, DOWN, REPEAT, RELEASE_CHK; 3-bit);
  - the default cycle constants for 50 MHz.
- Sub-module `sync_2ff`: a two-flop synchronizer with a reset value input. It is reused for the clear-button input.
- `key_pulse_gen` contains one FSM plus one counter of `CNT_W` bits.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=3, KEY_ACTIVE_LOW=1.
- Reset, then hold `key` = 1 for 50 cycles: all outputs stay 0.
- Drive `key` to 0 and hold: `press` is high for exactly the 7th edge only, and `key_level` = 1 from then on.
- Continue holding: `repeat_pulse` fires 10 cycles after `press`, then every 3 cycles, with `held` = 1. Release `key`: `release` is a one-cycle pulse 7 edges later, and `held` and `key_level` drop to 0.
- Glitch test: 3-cycle low pulses on `key` from IDLE, and 3-cycle high pulses while held. No `press` and no `release` occur, and `key_level` is unchanged.
- Assert `res` for 1 cycle while in REPEAT with `key` held low: all outputs are 0 the next cycle, then a fresh `press` fires 7 edges after `res` deasserts.
- REPEAT_EN=0 with `key` held for 100 cycles: exactly one `press`, zero `repeat_pulse`, and `held` stays 0.
